// File: rtl/uart_rx_word_if.sv
// rtl/uart_rx_word_if.sv - serial line and word-delivery signals of the 64-bit UART receiver
interface uart_rx_word_if;
  logic        rx;
  logic [63:0] rx_reg;
  logic        rx_dv;
  logic        rx_busy;
  logic        frame_err;
  logic [2:0]  byte_idx;

  modport master (
    output rx,
    input  rx_reg, rx_dv, rx_busy, frame_err, byte_idx
  );

  modport slave (
    input  rx,
    output rx_reg, rx_dv, rx_busy, frame_err, byte_idx
  );
endinterface

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - 8N1 LSB-first UART receiver packing eight bytes into one 64-bit word
// Partial words are dropped on a framing error or after TIMEOUT_BITS idle bit-times.
module uart_rx_word #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_word_if.slave bus
);
  localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IW     = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_BIT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IW-1:0] TO_END  = IW'(TO_CYC - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state;
  logic          rx_meta, rx_s;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [55:0]   buffer;
  logic [IW-1:0] idle_cnt;
  logic [63:0]   rx_reg_q;
  logic          rx_dv_q, frame_err_q, rx_busy_q;
  logic [2:0]    byte_idx_q;

  assign bus.rx_reg    = rx_reg_q;
  assign bus.rx_dv     = rx_dv_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy   = rx_busy_q;
  assign bus.byte_idx  = byte_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      buffer      <= '0;
      idle_cnt    <= '0;
      rx_reg_q    <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
      byte_idx_q  <= '0;
    end else begin
      rx_meta     <= bus.rx;
      rx_s        <= rx_meta;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          // Timeout and start edge may coincide; clearing byte_idx here makes the new byte slot 0.
          if (byte_idx_q != 3'd0) begin
            if (idle_cnt == TO_END) begin
              byte_idx_q <= '0;
              idle_cnt   <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          if (!rx_s) begin
            state     <= START;
            clk_cnt   <= '0;
            idle_cnt  <= '0;
            rx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == MID_BIT) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            if (rx_s) begin
              state     <= IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == BIT_END) begin
            clk_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == BIT_END) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state     <= IDLE;
              rx_busy_q <= 1'b0;
              if (byte_idx_q == 3'd7) begin
                rx_reg_q   <= {shift, buffer};
                rx_dv_q    <= 1'b1;
                byte_idx_q <= '0;
              end else begin
                buffer[{byte_idx_q, 3'b000} +: 8] <= shift;
                byte_idx_q <= byte_idx_q + 1'b1;
              end
            end else begin
              state       <= WAIT_HIGH;
              frame_err_q <= 1'b1;
              byte_idx_q  <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state     <= IDLE;
            rx_busy_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- UART receiver, 8N1, LSB-first. Assembles eight consecutive bytes into one 64-bit word.
- Return path from the host into the RingRAM design. Mirror of the 64-bit UART transmit path, in the clk_10 domain.
- Delivers each completed word on rx_reg with a one-cycle rx_dv strobe. Downstream uses it for command and config words, e.g. inverter select and cell-count requests.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200 ≈ 86.8). Must be ≥ 4.
- TIMEOUT_BITS, 20, idle bit-times after which a partial word is discarded.

Ports:
- clk  in  1  system clock (clk_10 domain)
- rst  in  1  asynchronous, active-low reset
- rx  in  1  serial input, idles high, asynchronous to clk
- rx_reg  out  64  last complete word; first received byte in [7:0], eighth byte in [63:56]
- rx_dv  out  1  one-cycle pulse; rx_reg is updated in the same cycle
- rx_busy  out  1  high while in any state other than IDLE
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low
- byte_idx  out  3  number of bytes accumulated in the current partial word (0..7)

Behaviour:
- Reset (rst=0, asynchronous):
  - rx_reg=0, rx_dv=0, frame_err=0, rx_busy=0, byte_idx=0.
  - State=IDLE, synchronizer flops=1, partial shift buffer cleared.
  - Release takes effect on the next clk edge.
- Input synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s, so there is 2 cycles of latency from pin to rx_s.
- State machine:
  - IDLE: wait for rx_s=0, then go to START with bit counter cleared.
  - START: count to (CLKS_PER_BIT-1)/2 (mid-bit) and sample rx_s.
    - rx_s=1: glitch. Return to IDLE with no output and byte_idx unchanged.
    - rx_s=0: go to DATA with counter cleared.
  - DATA: sample rx_s every CLKS_PER_BIT cycles, 8 samples, LSB first into the byte shift register.
  - STOP: sample rx_s after CLKS_PER_BIT cycles.
    - rx_s=1: valid byte. Write it to word buffer slot byte_idx and go to IDLE.
      - byte_idx<7: increment byte_idx.
      - byte_idx=7: in the same cycle load rx_reg from buffer plus this byte, pulse rx_dv, and set byte_idx=0.
    - rx_s=0: pulse frame_err, discard the byte, set byte_idx=0 (whole partial word dropped), go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A break condition never produces bytes.
- Inter-byte timeout:
  - Idle counter runs only in IDLE with byte_idx≠0. It clears on leaving IDLE.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT cycles sets byte_idx=0 silently (no pulse).
  - If the timeout and a start edge land in the same cycle, the timeout wins: the new byte becomes byte 0.
- rx_reg holds its value between completions. It never changes on error or timeout.
- rx_dv and frame_err are mutually exclusive and never asserted for more than 1 cycle.
- Latency: rx_dv rises ~2 + 9.5·CLKS_PER_BIT + 1 cycles after the falling edge of the 8th byte's start bit. Tolerance is ±1 cycle.
- Back-to-back frames (stop bit followed immediately by a start bit) are received without loss. The STOP→IDLE transition takes 1 cycle, and detection happens within half a bit.
- Asynchronous reset mid-frame aborts cleanly. After release, a mid-frame line produces at most a glitch rejection or a frame_err, never a false rx_dv.

Test Plan:
- CLKS_PER_BIT=8. Send bytes 0x01,0x23,0x45,0x67,0x89,0xAB,0xCD,0xEF back-to-back -> exactly one rx_dv pulse; rx_reg=64'hEFCDAB8967452301; frame_err never asserted; byte_idx counts 1..7 then 0.
- Two full words back-to-back (second is 0xFF×8) -> two rx_dv pulses; rx_reg ends at 64'hFFFFFFFFFFFFFFFF; first value held until the second pulse.
- Low glitch of 2 cycles on idle rx -> no state progress beyond START, no outputs; byte_idx unchanged.
- 3 valid bytes, then a 4th byte with stop bit forced low -> frame_err one pulse, byte_idx=0, no rx_dv. With rx held low 30 bit-times, FSM stays in WAIT_HIGH. A following 8-byte word is received correctly.
- TIMEOUT_BITS=4. Send 5 bytes, idle 5 bit-times, then 8 bytes 0x10..0x17 -> one rx_dv only; rx_reg=64'h1716151413121110.
- Assert rst during the DATA bits of byte 6 -> all outputs 0 immediately (asynchronous). After release and line idle, a clean 8-byte word produces a correct rx_dv.
